// File: rtl/commit_progress_monitor_if.sv
// Commit-side bus between the commit stage / run controller and commit_progress_monitor.
// The controller side drives run control and per-lane commit info; the monitor returns run statistics.
interface commit_progress_monitor_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32
);
  logic                             start;
  logic [CNT_WIDTH-1:0]             maxCycles;
  logic [PC_WIDTH-1:0]              pcGoal;
  logic                             goalEn;
  logic [COMMIT_WIDTH-1:0]          commit;
  logic [COMMIT_WIDTH-1:0]          commitMidZero;
  logic [COMMIT_WIDTH*PC_WIDTH-1:0] commitPc;
  logic                             ack;

  logic                             running;
  logic                             done;
  logic [1:0]                       doneCause;
  logic [CNT_WIDTH-1:0]             cycleCount;
  logic [CNT_WIDTH-1:0]             microOpCount;
  logic [CNT_WIDTH-1:0]             riscvOpCount;
  logic [PC_WIDTH-1:0]              lastCommittedPc;

  modport master (
    output start, maxCycles, pcGoal, goalEn, commit, commitMidZero, commitPc, ack,
    input  running, done, doneCause, cycleCount, microOpCount, riscvOpCount, lastCommittedPc
  );

  modport slave (
    input  start, maxCycles, pcGoal, goalEn, commit, commitMidZero, commitPc, ack,
    output running, done, doneCause, cycleCount, microOpCount, riscvOpCount, lastCommittedPc
  );
endinterface

// File: rtl/commit_progress_monitor.sv
// Run monitor on the commit side: counts cycles / micro-ops / RISC-V ops and ends a run on goal PC,
// cycle budget or commit starvation. Hang detection is built only when RSD_COMMIT_MONITOR_HANG_DETECT_EN is defined.
module commit_progress_monitor #(
  parameter int COMMIT_WIDTH   = 2,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int GOAL_CMP_WIDTH = 16,
  parameter int HANG_CYCLES    = 4096
) (
  input logic                    clk,
  input logic                    rstOut,
  commit_progress_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0]           CAUSE_NONE    = 2'd0;
  localparam logic [1:0]           CAUSE_GOAL    = 2'd1;
  localparam logic [1:0]           CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0]           CAUSE_HANG    = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE       = CNT_WIDTH'(1'b1);

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [COMMIT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      n = n + CNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[CNT_WIDTH]) begin
      return '1;
    end else begin
      return s[CNT_WIDTH-1:0];
    end
  endfunction

  state_e                    state_q, state_d;
  logic                      running_q, running_d;
  logic                      done_q, done_d;
  logic [1:0]                cause_q, cause_d;
  logic [CNT_WIDTH-1:0]      cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]      uop_q, uop_d;
  logic [CNT_WIDTH-1:0]      rvop_q, rvop_d;
  logic [PC_WIDTH-1:0]       last_pc_q, last_pc_d;
  logic [CNT_WIDTH-1:0]      max_cycles_q, max_cycles_d;
  logic [GOAL_CMP_WIDTH-1:0] goal_q, goal_d;
  logic                      goal_en_q, goal_en_d;

`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
  localparam int IDLE_W = $clog2(HANG_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  logic                any_commit_s;
  logic                goal_hit_s;
  logic [PC_WIDTH-1:0] lane_pc_s;
  logic [PC_WIDTH-1:0] top_lane_pc_s;
  logic                goal_s;
  logic                timeout_s;
  logic                hang_s;

  assign any_commit_s = |mon.commit;

  // Per-lane decode: PC of the highest committing lane and goal match on any committing lane.
  always_comb begin
    lane_pc_s     = '0;
    top_lane_pc_s = '0;
    goal_hit_s    = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_pc_s = mon.commitPc[i*PC_WIDTH +: PC_WIDTH];
      if (mon.commit[i]) begin
        top_lane_pc_s = lane_pc_s;
        goal_hit_s    = goal_hit_s | (lane_pc_s[GOAL_CMP_WIDTH-1:0] == goal_q);
      end else begin
        goal_hit_s    = goal_hit_s;
      end
    end
  end

  // Run FSM next-state, counter updates and termination priority.
  always_comb begin
    state_d      = state_q;
    running_d    = running_q;
    done_d       = done_q;
    cause_d      = cause_q;
    cycle_d      = cycle_q;
    uop_d        = uop_q;
    rvop_d       = rvop_q;
    last_pc_d    = last_pc_q;
    max_cycles_d = max_cycles_q;
    goal_d       = goal_q;
    goal_en_d    = goal_en_q;
    goal_s       = 1'b0;
    timeout_s    = 1'b0;
    hang_s       = 1'b0;
`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
    idle_d       = idle_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (mon.start) begin
          state_d      = ST_RUN;
          running_d    = 1'b1;
          done_d       = 1'b0;
          cause_d      = CAUSE_NONE;
          cycle_d      = '0;
          uop_d        = '0;
          rvop_d       = '0;
          last_pc_d    = '0;
          max_cycles_d = mon.maxCycles;
          goal_d       = mon.pcGoal[GOAL_CMP_WIDTH-1:0];
          goal_en_d    = mon.goalEn;
`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
          idle_d       = '0;
`endif
        end else begin
          state_d      = ST_IDLE;
        end
      end

      ST_RUN: begin
        cycle_d = sat_add(cycle_q, CNT_ONE);
        uop_d   = sat_add(uop_q, popcount(mon.commit));
        rvop_d  = sat_add(rvop_q, popcount(mon.commit & mon.commitMidZero));
        if (any_commit_s) begin
          last_pc_d = top_lane_pc_s;
        end else begin
          last_pc_d = last_pc_q;
        end
`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
        if (any_commit_s) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1'b1);
        end
        hang_s = (idle_d == IDLE_W'(HANG_CYCLES));
`endif
        goal_s    = goal_en_q & goal_hit_s;
        // Timeout compares the already-incremented count so the budget cycle itself is counted.
        timeout_s = (max_cycles_q != '0) && (cycle_d == max_cycles_q);
        if (goal_s) begin
          state_d = ST_DONE;
          cause_d = CAUSE_GOAL;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          cause_d = CAUSE_TIMEOUT;
        end else if (hang_s) begin
          state_d = ST_DONE;
          cause_d = CAUSE_HANG;
        end else begin
          state_d = ST_RUN;
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
      end

      ST_DONE: begin
        if (mon.ack) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  // State and result registers, cleared asynchronously by rstOut.
  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      state_q      <= ST_IDLE;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      cause_q      <= CAUSE_NONE;
      cycle_q      <= '0;
      uop_q        <= '0;
      rvop_q       <= '0;
      last_pc_q    <= '0;
      max_cycles_q <= '0;
      goal_q       <= '0;
      goal_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      done_q       <= done_d;
      cause_q      <= cause_d;
      cycle_q      <= cycle_d;
      uop_q        <= uop_d;
      rvop_q       <= rvop_d;
      last_pc_q    <= last_pc_d;
      max_cycles_q <= max_cycles_d;
      goal_q       <= goal_d;
      goal_en_q    <= goal_en_d;
    end
  end

`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
  // Consecutive commit-free RUN cycles.
  always_ff @(posedge clk or negedge rstOut) begin
    if (!rstOut) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign mon.running         = running_q;
  assign mon.done            = done_q;
  assign mon.doneCause       = cause_q;
  assign mon.cycleCount      = cycle_q;
  assign mon.microOpCount    = uop_q;
  assign mon.riscvOpCount    = rvop_q;
  assign mon.lastCommittedPc = last_pc_q;

endmodule

// File: tb/tb_commit_progress_monitor.sv
// Randomized + directed bench for commit_progress_monitor against an abstract run model.
module tb_commit_progress_monitor;
  localparam int CW   = 2;
  localparam int PW   = 32;
  localparam int NW   = 8;
  localparam int GW   = 16;
  localparam int HC   = 8;
  localparam int MAXC = 255;
`ifdef RSD_COMMIT_MONITOR_HANG_DETECT_EN
  localparam bit HANG_ON = 1'b1;
`else
  localparam bit HANG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstOut;
  always #5 clk = ~clk;

  commit_progress_monitor_if #(.COMMIT_WIDTH(CW), .PC_WIDTH(PW), .CNT_WIDTH(NW)) bus();

  commit_progress_monitor #(
    .COMMIT_WIDTH(CW), .PC_WIDTH(PW), .CNT_WIDTH(NW), .GOAL_CMP_WIDTH(GW), .HANG_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rstOut(rstOut),
    .mon(bus)
  );

  int checks = 0;
  int errors = 0;

  // Abstract run model: mode 0 idle, 1 running, 2 finished.
  int          m_mode, m_cyc, m_uop, m_rv, m_cause, m_max, m_idle;
  bit          m_goal_en;
  logic [31:0] m_goal, m_last;

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cyc = 0; m_uop = 0; m_rv = 0; m_cause = 0; m_max = 0; m_idle = 0;
    m_goal_en = 1'b0; m_goal = '0; m_last = '0;
  endtask

  task automatic model_edge();
    int nc, nr;
    bit g, to, hg, found;
    logic [31:0] pc;
    if (!rstOut) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (bus.start) begin
        m_mode = 1; m_cyc = 0; m_uop = 0; m_rv = 0; m_cause = 0; m_last = '0; m_idle = 0;
        m_max = int'(bus.maxCycles); m_goal = bus.pcGoal; m_goal_en = bus.goalEn;
      end
    end else if (m_mode == 1) begin
      nc = $countones(bus.commit);
      nr = $countones(bus.commit & bus.commitMidZero);
      m_cyc = sat(m_cyc + 1);
      m_uop = sat(m_uop + nc);
      m_rv  = sat(m_rv + nr);
      g = 1'b0; found = 1'b0;
      for (int i = CW - 1; i >= 0; i--) begin
        if (bus.commit[i]) begin
          pc = bus.commitPc[i*PW +: PW];
          if (!found) m_last = pc;
          found = 1'b1;
          if (m_goal_en && pc[15:0] == m_goal[15:0]) g = 1'b1;
        end
      end
      m_idle = (nc == 0) ? m_idle + 1 : 0;
      to = (m_max != 0) && (m_cyc == m_max);
      hg = HANG_ON && (m_idle >= HC);
      if (g)       begin m_mode = 2; m_cause = 1; end
      else if (to) begin m_mode = 2; m_cause = 2; end
      else if (hg) begin m_mode = 2; m_cause = 3; end
    end else if (bus.ack) begin
      m_mode = 0;
    end
  endtask

  task automatic compare_all();
    chk("running", bus.running, 64'(m_mode == 1));
    chk("done", bus.done, 64'(m_mode == 2));
    chk("doneCause", bus.doneCause, 64'(m_cause));
    chk("cycleCount", bus.cycleCount, 64'(m_cyc));
    chk("microOpCount", bus.microOpCount, 64'(m_uop));
    chk("riscvOpCount", bus.riscvOpCount, 64'(m_rv));
    chk("lastCommittedPc", bus.lastCommittedPc, 64'(m_last));
  endtask

  // One clock: model follows the active edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic lanes(input logic [1:0] c, input logic [1:0] m, input logic [31:0] p0, input logic [31:0] p1);
    bus.commit = c; bus.commitMidZero = m; bus.commitPc = {p1, p0};
  endtask

  task automatic do_start(input int maxc, input logic [31:0] goal, input bit gen);
    bus.maxCycles = NW'(maxc); bus.pcGoal = goal; bus.goalEn = gen;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin tick(); n++; end
    chk(nm, bus.done, 64'(1));
  endtask

  task automatic pulse_reset();
    #2 rstOut = 1'b0;
    #1 model_reset();
    compare_all();
    tick();
    rstOut = 1'b1;
  endtask

  localparam int T4_CYC = HANG_ON ? 9 : 20;

  initial begin
    int n;
    bus.start = 1'b0; bus.ack = 1'b0; bus.maxCycles = '0; bus.pcGoal = '0; bus.goalEn = 1'b0;
    lanes(2'b00, 2'b00, 32'h0, 32'h0);
    model_reset();
    rstOut = 1'b1;
    #1 rstOut = 1'b0;
    @(negedge clk); compare_all();
    tick();
    rstOut = 1'b1;
    tick();

    // Timeout: 10-cycle budget, both lanes commit, lane0 is first micro-op.
    lanes(2'b11, 2'b01, 32'h100, 32'h104);
    do_start(10, 32'h0, 1'b0);
    chk("t1_running", bus.running, 64'(1));
    wait_done("t1_wait", 40, n);
    chk("t1_latency", 64'(n), 64'(10));
    chk("t1_cause", bus.doneCause, 64'(2));
    chk("t1_cyc", bus.cycleCount, 64'(10));
    chk("t1_uop", bus.microOpCount, 64'(20));
    chk("t1_rv", bus.riscvOpCount, 64'(10));
    chk("t1_last", bus.lastCommittedPc, 64'h104);
    do_ack();
    chk("t1_ack_done", bus.done, 64'(0));

    // Goal on lane1 in 5th RUN cycle, upper PC bits ignored.
    lanes(2'b01, 2'b01, 32'h200, 32'h0);
    do_start(0, 32'h0000_1040, 1'b1);
    repeat (4) tick();
    lanes(2'b10, 2'b10, 32'h0, 32'h8000_1040);
    tick();
    chk("t2_done", bus.done, 64'(1));
    chk("t2_cause", bus.doneCause, 64'(1));
    chk("t2_cyc", bus.cycleCount, 64'(5));
    chk("t2_last", bus.lastCommittedPc, 64'h8000_1040);
    do_ack();

    // Goal and budget end in the same cycle: goal wins.
    lanes(2'b11, 2'b11, 32'h300, 32'h304);
    do_start(3, 32'h0000_1040, 1'b1);
    repeat (2) tick();
    lanes(2'b11, 2'b11, 32'h0000_1040, 32'h308);
    tick();
    chk("t3_cause", bus.doneCause, 64'(1));
    chk("t3_cyc", bus.cycleCount, 64'(3));
    chk("t3_last", bus.lastCommittedPc, 64'h308);
    do_ack();

    // One commit, then starvation.
    lanes(2'b01, 2'b01, 32'h500, 32'h0);
    do_start(20, 32'h0, 1'b0);
    tick();
    lanes(2'b00, 2'b00, 32'h0, 32'h0);
    wait_done("t4_wait", 40, n);
    chk("t4_cause", bus.doneCause, HANG_ON ? 64'(3) : 64'(2));
    chk("t4_cyc", bus.cycleCount, 64'(T4_CYC));
    chk("t4_uop", bus.microOpCount, 64'(1));
    chk("t4_last", bus.lastCommittedPc, 64'h500);

    // start in DONE ignored; ack with start returns to IDLE only.
    bus.maxCycles = 8'd5; bus.start = 1'b1; tick();
    chk("t5_start_in_done", bus.done, 64'(1));
    chk("t5_cyc_held", bus.cycleCount, 64'(T4_CYC));
    bus.ack = 1'b1; tick(); bus.ack = 1'b0; bus.start = 1'b0;
    chk("t5_idle_running", bus.running, 64'(0));
    chk("t5_idle_done", bus.done, 64'(0));
    chk("t5_cyc_kept", bus.cycleCount, 64'(T4_CYC));
    tick();
    lanes(2'b11, 2'b11, 32'h600, 32'h604);
    do_start(0, 32'h0, 1'b0);
    chk("t5_cleared_cyc", bus.cycleCount, 64'(0));
    chk("t5_cleared_uop", bus.microOpCount, 64'(0));
    chk("t5_cleared_pc", bus.lastCommittedPc, 64'(0));
    chk("t5_cleared_cause", bus.doneCause, 64'(0));

    // Reset in mid-run with 7 micro-ops counted.
    repeat (3) tick();
    lanes(2'b01, 2'b00, 32'h700, 32'h0);
    tick();
    chk("t6_uop", bus.microOpCount, 64'(7));
    pulse_reset();
    chk("t6_rst_uop", bus.microOpCount, 64'(0));
    lanes(2'b11, 2'b11, 32'h800, 32'h804);
    repeat (3) tick();
    chk("t6_no_run", bus.running, 64'(0));
    chk("t6_no_count", bus.microOpCount, 64'(0));

    // Saturation with unlimited budget, ended by goal.
    do_start(0, 32'h0000_BEEF, 1'b1);
    repeat (300) tick();
    chk("sat_cyc", bus.cycleCount, 64'(MAXC));
    chk("sat_uop", bus.microOpCount, 64'(MAXC));
    chk("sat_rv", bus.riscvOpCount, 64'(MAXC));
    lanes(2'b10, 2'b00, 32'h0, 32'h1234_BEEF);
    tick();
    chk("sat_goal_cause", bus.doneCause, 64'(1));
    do_ack();

    // Budget of one cycle.
    do_start(1, 32'h0, 1'b0);
    tick();
    chk("max1_done", bus.done, 64'(1));
    do_ack();

    // Random traffic.
    for (int k = 0; k < 4000; k++) begin
      logic [31:0] lows [4];
      logic [31:0] p0, p1;
      lows[0] = 32'h1040; lows[1] = 32'h2000; lows[2] = 32'h3000; lows[3] = $urandom & 32'hFFFF;
      p0 = {16'($urandom), lows[$urandom_range(0, 3)][15:0]};
      p1 = {16'($urandom), lows[$urandom_range(0, 3)][15:0]};
      bus.start = ($urandom_range(0, 7) == 0);
      bus.ack   = ($urandom_range(0, 5) == 0);
      bus.maxCycles = NW'($urandom_range(0, 30));
      bus.pcGoal = {16'($urandom), lows[$urandom_range(0, 2)][15:0]};
      bus.goalEn = $urandom_range(0, 1);
      if (((k / 64) % 3) == 2) lanes(2'b00, 2'($urandom), p0, p1);
      else lanes(2'($urandom), 2'($urandom), p0, p1);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/commit_progress_monitor.md
# commit_progress_monitor

Synthesizable run monitor on the commit side of the core: it consumes per-lane commit strobes, micro-op ID flags and PCs from the commit stage, and produces the run statistics and end-of-run verdict the simulation top and the on-board debug path report. It counts elapsed cycles, committed micro-ops and committed RISC-V ops, and ends a run on PC-goal match, cycle budget exhaustion or commit starvation (hang). Results are held until acknowledged.

## Interface
Parameters:
- COMMIT_WIDTH, 2, commit lanes per cycle
- PC_WIDTH, 32, PC width
- CNT_WIDTH, 32, width of all counters
- GOAL_CMP_WIDTH, 16, low PC bits compared against the goal
- HANG_CYCLES, 4096, consecutive commit-free cycles that declare a hang

Ports:
- clk  in  1  clock
- rstOut  in  1  reset, asynchronous, active-low
- start  in  1  pulse; begins a run (sampled in IDLE only)
- maxCycles  in  CNT_WIDTH  cycle budget, latched on start; 0 = unlimited
- pcGoal  in  PC_WIDTH  goal PC, latched on start
- goalEn  in  1  enables goal detection, latched on start
- commit  in  COMMIT_WIDTH  per-lane commit valid
- commitMidZero  in  COMMIT_WIDTH  per-lane: op is first micro-op of its RISC-V instruction (mid == 0)
- commitPc  in  COMMIT_WIDTH*PC_WIDTH  per-lane PC, lane i at bits [i*PC_WIDTH +: PC_WIDTH]
- ack  in  1  pulse; releases results, returns to IDLE
- running  out  1  high in RUN
- done  out  1  high in DONE
- doneCause  out  2  0 none, 1 goal, 2 timeout, 3 hang
- cycleCount  out  CNT_WIDTH  RUN cycles elapsed
- microOpCount  out  CNT_WIDTH  committed micro-ops
- riscvOpCount  out  CNT_WIDTH  committed ops with commitMidZero
- lastCommittedPc  out  PC_WIDTH  PC of highest-index committing lane, last cycle with any commit

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE: start -> RUN; all counters, lastCommittedPc, doneCause cleared to 0 on that edge; config latched. Commit inputs ignored.
- RUN, every cycle: cycleCount += 1; microOpCount += popcount(commit); riscvOpCount += popcount(commit & commitMidZero); if any commit, lastCommittedPc <= PC of highest set lane. Counters saturate at all-ones.
- Goal: in RUN, if goalEn and any committing lane's PC[GOAL_CMP_WIDTH-1:0] == pcGoal[GOAL_CMP_WIDTH-1:0] -> DONE, cause 1. Commits of that cycle are counted.
- Timeout: maxCycles != 0 and updated cycleCount == maxCycles -> DONE, cause 2.
- Hang: idle counter increments each RUN cycle with no commit, clears on any commit; reaching HANG_CYCLES -> DONE, cause 3.
- Simultaneous terminations: goal > timeout > hang.
- DONE: all outputs frozen; commit inputs ignored; start ignored; ack -> IDLE (counters keep values until next start).
- start in RUN or DONE ignored; ack in IDLE or RUN ignored.

## Timing
- Reset values: running 0, done 0, doneCause 0, all counters 0, lastCommittedPc 0, state IDLE.
- start at edge N: running 1 from N+1; first counted commit cycle is N+1.
- Termination condition in cycle M: done and doneCause visible after edge M, running 0 same edge; counters include cycle M.
- ack at edge K in DONE: done 0, IDLE after K.
- Reset assertion mid-run: immediate return to reset values, no verdict retained.
- Counter wrap never occurs; saturation holds at 2^CNT_WIDTH-1.

## Configuration
- RSD_COMMIT_MONITOR_HANG_DETECT_EN: defined -> idle counter and cause 3 implemented as above. Undefined -> no idle counter is built, cause 3 never produced, runs end only by goal or timeout.

## Test plan
- start, maxCycles=10, goalEn=0, commit=2'b11, commitMidZero=2'b01 every cycle -> done after 10 RUN cycles, cause 2, cycleCount 10, microOpCount 20, riscvOpCount 10.
- goalEn=1, pcGoal=0x0000_1040; lane1 commits PC 0x8000_1040 in 5th RUN cycle -> cause 1, cycleCount 5, lastCommittedPc 0x8000_1040.
- Goal match on the same cycle cycleCount reaches maxCycles -> cause 1 (goal wins).
- With hang detect, HANG_CYCLES=8, one commit then no commits -> cause 3 after 9 RUN cycles; without macro -> stays RUN until maxCycles.
- start while DONE, then ack together with start -> start ignored, IDLE, counters unchanged; next start clears all to 0.
- rstOut low in mid-RUN with microOpCount=7 -> all outputs 0 asynchronously; post-reset start required to run.
